fmac_feeder: RTL and testbench

Operand sequencer that drives the `x`/`y` inputs of the 8x8 multiply-accumulate unit. A host pushes operand pairs into an internal FIFO through a valid/ready handshake. On `start`, the block clears the MAC's accumulator, streams exactly `len` pairs into it, and inserts zero bubbles whenever the FIFO runs dry. It then holds zeros for a drain period so the MAC pipeline settles, and pulses `done`.

---
 rtl/fmac_feeder_if.sv | 25 ++
 rtl/fmac_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_fmac_feeder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmac_feeder_if.sv
// fmac_feeder_if: host-side operand push channel of fmac_feeder.
// The host (master) offers an x/y operand pair with in_valid; the feeder
// (slave) accepts it in any cycle where in_ready is high.
interface fmac_feeder_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;

  modport master (
    output in_valid,
    output in_x,
    output in_y,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_x,
    input  in_y,
    output in_ready
  );
endinterface

// File: rtl/fmac_feeder.sv
// fmac_feeder: operand sequencer for the 8x8 multiply-accumulate unit.
// Host pairs are buffered in a DEPTH-entry FIFO. On start the MAC accumulator
// is cleared, len pairs are streamed onto x/y (zero bubbles whenever the FIFO
// is dry), DRAIN_CYCLES zero cycles let the MAC pipeline settle, then done
// pulses for one cycle. Pairs left in the FIFO carry over to the next vector.
// Optional feature macro: FMAC_FEEDER_ABORT_EN adds an abort input that drops
// the current vector, flushes the FIFO and clears the MAC accumulator.
module fmac_feeder #(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         start,
  input  logic [7:0]   len,
`ifdef FMAC_FEEDER_ABORT_EN
  input  logic         abort,
`endif
  fmac_feeder_if.slave host,
  output logic [7:0]   x,
  output logic [7:0]   y,
  output logic         mac_clr_n,
  output logic         busy,
  output logic         done,
  output logic [7:0]   count
);

  localparam int DATA_W = 8;
  localparam int PW     = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int DCW    = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [PW:0]    OCC_FULL   = (PW + 1)'(DEPTH);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  // The state register names what the registered outputs show in that cycle:
  // CLEAR has mac_clr_n low, RUN shows issued pairs or bubbles, DRAIN shows
  // the settling zeros, DONE shows the done pulse.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [7:0]         len_r;
  logic [DCW-1:0]     drain_cnt;

  logic [DATA_W-1:0]  mem_x [DEPTH];
  logic [DATA_W-1:0]  mem_y [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        occ;

  logic               full;
  logic               empty;
  logic               issue;
  logic               push;
  logic               pop;
  logic               abort_act;

`ifdef FMAC_FEEDER_ABORT_EN
  // Abort only acts while a vector is in flight.
  assign abort_act = abort && ((state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN));
`else
  assign abort_act = 1'b0;
`endif

  assign full          = (occ == OCC_FULL);
  assign empty         = (occ == '0);
  assign host.in_ready = !full;

  // The edge leaving CLEAR already issues the first pair, so that pair is on
  // x/y in the first RUN cycle; RUN keeps issuing until len pairs are out.
  assign issue = (state == S_CLEAR) || ((state == S_RUN) && (count != len_r));

  // in_ready looks only at full, so a full FIFO refuses a push even when a
  // pop happens in the same cycle; an abort drops any same-cycle push.
  assign push = host.in_valid && !full && !abort_act;
  assign pop  = issue && !empty && !abort_act;

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (abort_act) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_x[wr_ptr] <= host.in_x;
      mem_y[wr_ptr] <= host.in_y;
    end
  end

  // Sequencer FSM with registered MAC-side outputs and status.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      len_r     <= '0;
      drain_cnt <= '0;
      x         <= '0;
      y         <= '0;
      mac_clr_n <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
    end else begin
      x         <= '0;
      y         <= '0;
      mac_clr_n <= 1'b1;
      done      <= 1'b0;

      if (abort_act) begin
        state     <= S_IDLE;
        mac_clr_n <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (pop) begin
          x     <= mem_x[rd_ptr];
          y     <= mem_y[rd_ptr];
          count <= count + 1'b1;
        end

        case (state)
          S_IDLE: begin
            if (start) begin
              if (len != 8'd0) begin
                len_r     <= len;
                count     <= '0;
                mac_clr_n <= 1'b0;
                busy      <= 1'b1;
                state     <= S_CLEAR;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end

          S_CLEAR: begin
            state <= S_RUN;
          end

          S_RUN: begin
            if (count == len_r) begin
              if (DRAIN_CYCLES == 0) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                drain_cnt <= DRAIN_LAST;
                state     <= S_DRAIN;
              end
            end
          end

          S_DRAIN: begin
            if (drain_cnt == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end

          S_DONE: begin
            state <= S_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fmac_feeder.sv
// tb_fmac_feeder: directed self-checking bench for fmac_feeder
// (DEPTH=4, DRAIN_CYCLES=2). Define FMAC_FEEDER_ABORT_EN to include the
// abort scenario.
module tb_fmac_feeder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       start;
  logic [7:0] len;
  logic       abort;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] count;
  logic       mac_clr_n;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  logic [15:0] cap_xy   [0:31];
  logic        cap_clr  [0:31];
  logic        cap_done [0:31];
  logic        cap_busy [0:31];
  logic [7:0]  cap_cnt  [0:31];
  logic        rdy      [0:7];

  fmac_feeder_if #(.DATA_W(8)) hif ();

  fmac_feeder #(
    .DEPTH        (4),
    .DRAIN_CYCLES (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .len       (len),
`ifdef FMAC_FEEDER_ABORT_EN
    .abort     (abort),
`endif
    .host      (hif),
    .x         (x),
    .y         (y),
    .mac_clr_n (mac_clr_n),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] px, input logic [7:0] py);
    hif.in_valid = 1'b1;
    hif.in_x     = px;
    hif.in_y     = py;
    tick();
    hif.in_valid = 1'b0;
  endtask

  // Start is sampled at edge t; afterwards we sit in cycle t+1.
  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Records cycles t+1..t+n; optional push/start/abort driven at edge t+k.
  task automatic capture(input int n, input int push_k, input logic [7:0] px,
                         input logic [7:0] py, input int start_k,
                         input logic [7:0] slen, input int abort_k);
    for (int k = 1; k <= n; k++) begin
      cap_xy[k]   = {x, y};
      cap_clr[k]  = mac_clr_n;
      cap_done[k] = done;
      cap_busy[k] = busy;
      cap_cnt[k]  = count;
      if (k == push_k) begin
        hif.in_valid = 1'b1;
        hif.in_x     = px;
        hif.in_y     = py;
      end else begin
        hif.in_valid = 1'b0;
      end
      if (k == start_k) begin
        start = 1'b1;
        len   = slen;
      end else begin
        start = 1'b0;
      end
      abort = (k == abort_k);
      tick();
    end
    hif.in_valid = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
  endtask

  function automatic int first_done(input int n);
    for (int k = 1; k <= n; k++) begin
      if (cap_done[k]) return k;
    end
    return 0;
  endfunction

  function automatic int done_pulses(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) begin
      if (cap_done[k]) c++;
    end
    return c;
  endfunction

  function automatic int prod_sum(input int n);
    int s = 0;
    for (int k = 1; k <= n; k++) begin
      s += int'(cap_xy[k][15:8]) * int'(cap_xy[k][7:0]);
    end
    return s;
  endfunction

  initial begin
    RESET        = 1'b0;
    start        = 1'b0;
    len          = 8'd0;
    abort        = 1'b0;
    hif.in_valid = 1'b0;
    hif.in_x     = 8'd0;
    hif.in_y     = 8'd0;
    tick();
    tick();

    // Reset state
    chk("rst_xy",       32'({x, y}),      32'h0);
    chk("rst_clr_n",    32'(mac_clr_n),   32'd1);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_done",     32'(done),        32'd0);
    chk("rst_count",    32'(count),       32'd0);
    chk("rst_in_ready", 32'(hif.in_ready), 32'd1);
    RESET = 1'b1;
    tick();

    // Basic vector, no bubbles
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    do_start(8'd3);
    capture(9, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("v1_clr_low",   32'(cap_clr[1]),  32'd0);
    chk("v1_clr_high",  32'(cap_clr[2]),  32'd1);
    chk("v1_busy_clr",  32'(cap_busy[1]), 32'd1);
    chk("v1_pair1",     32'(cap_xy[2]),   32'h0304);
    chk("v1_pair2",     32'(cap_xy[3]),   32'h0506);
    chk("v1_pair3",     32'(cap_xy[4]),   32'h0708);
    chk("v1_drain0",    32'(cap_xy[5]),   32'h0);
    chk("v1_busy_drn",  32'(cap_busy[6]), 32'd1);
    chk("v1_done_at",   32'(first_done(9)),  32'd7);
    chk("v1_done_once", 32'(done_pulses(9)), 32'd1);
    chk("v1_busy_done", 32'(cap_busy[7]), 32'd0);
    chk("v1_count",     32'(cap_cnt[7]),  32'd3);
    chk("v1_count_hold", 32'(cap_cnt[9]), 32'd3);
    chk("v1_mac_sum",   32'(prod_sum(9)), 32'(3 * 4 + 5 * 6 + 7 * 8));

    // Bubbles: second pair pushed at edge t+4, start pulse in RUN ignored
    push(8'd2, 8'd9);
    do_start(8'd2);
    capture(12, 4, 8'd6, 8'd1, 3, 8'd5, 0);
    chk("v2_pair1",     32'(cap_xy[2]), 32'h0209);
    chk("v2_bubbles",   32'(cap_xy[3] | cap_xy[4] | cap_xy[5]), 32'h0);
    chk("v2_pair2",     32'(cap_xy[6]), 32'h0601);
    chk("v2_done_at",   32'(first_done(12)),  32'd9);
    chk("v2_done_once", 32'(done_pulses(12)), 32'd1);
    chk("v2_count",     32'(cap_cnt[9]), 32'd2);

    // FIFO fill with in_valid held high, no start
    hif.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rdy[i]   = hif.in_ready;
      hif.in_x = 8'(8'h11 + i);
      hif.in_y = 8'(8'h21 + i);
      tick();
    end
    hif.in_valid = 1'b0;
    chk("fill_rdy_4", 32'(rdy[0] & rdy[1] & rdy[2] & rdy[3]), 32'd1);
    chk("fill_rdy_5", 32'(rdy[4]), 32'd0);
    chk("fill_rdy_6", 32'(rdy[5]), 32'd0);
    chk("fill_full",  32'(hif.in_ready), 32'd0);
    do_start(8'd4);
    capture(10, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("v3_pair1",   32'(cap_xy[2]), 32'h1121);
    chk("v3_pair2",   32'(cap_xy[3]), 32'h1222);
    chk("v3_pair3",   32'(cap_xy[4]), 32'h1323);
    chk("v3_pair4",   32'(cap_xy[5]), 32'h1424);
    chk("v3_done_at", 32'(first_done(10)), 32'd8);
    chk("v3_count",   32'(cap_cnt[8]), 32'd4);
    chk("v3_ready",   32'(hif.in_ready), 32'd1);

    // len=0 leaves the FIFO alone; the fifth fill pair was never stored
    push(8'h55, 8'h66);
    do_start(8'd0);
    capture(4, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("z_done_at", 32'(first_done(4)), 32'd1);
    chk("z_clr_n",   32'(cap_clr[1] & cap_clr[2] & cap_clr[3] & cap_clr[4]), 32'd1);
    chk("z_busy",    32'(cap_busy[1]), 32'd0);
    do_start(8'd1);
    capture(6, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("z_pair_kept", 32'(cap_xy[2]), 32'h5566);
    chk("z_done_len1", 32'(first_done(6)), 32'd5);

    // Asynchronous reset in the middle of RUN
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    push(8'h05, 8'h06);
    do_start(8'd3);
    tick();
    chk("r_run_pair", 32'({x, y}), 32'h0102);
    #2;
    RESET = 1'b0;
    #1;
    chk("r_async_xy",    32'({x, y}),       32'h0);
    chk("r_async_clr_n", 32'(mac_clr_n),    32'd1);
    chk("r_async_busy",  32'(busy),         32'd0);
    chk("r_async_done",  32'(done),         32'd0);
    chk("r_async_count", 32'(count),        32'd0);
    chk("r_async_ready", 32'(hif.in_ready), 32'd1);
    tick();
    tick();
    RESET = 1'b1;
    capture(8, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("r_no_done", 32'(done_pulses(8)), 32'd0);
    push(8'h0A, 8'h0B);
    do_start(8'd1);
    capture(6, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("r_fifo_flushed", 32'(cap_xy[2]), 32'h0A0B);

`ifdef FMAC_FEEDER_ABORT_EN
    // Abort in RUN after two of five pairs, with a same-cycle push
    push(8'h21, 8'h31);
    push(8'h22, 8'h32);
    push(8'h23, 8'h33);
    push(8'h24, 8'h34);
    do_start(8'd5);
    capture(10, 3, 8'h99, 8'h98, 0, 8'd0, 3);
    chk("a_pair1",     32'(cap_xy[2]),   32'h2131);
    chk("a_pair2",     32'(cap_xy[3]),   32'h2232);
    chk("a_clr_low",   32'(cap_clr[4]),  32'd0);
    chk("a_clr_high",  32'(cap_clr[5]),  32'd1);
    chk("a_idle",      32'(cap_busy[4]), 32'd0);
    chk("a_xy_zero",   32'(cap_xy[4]),   32'h0);
    chk("a_count",     32'(cap_cnt[4]),  32'd2);
    chk("a_no_done",   32'(done_pulses(10)), 32'd0);
    push(8'h44, 8'h45);
    do_start(8'd1);
    capture(6, 0, 8'd0, 8'd0, 0, 8'd0, 0);
    chk("a_fifo_flushed", 32'(cap_xy[2]), 32'h4445);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
